// File: rtl/sparse_mult_arbiter.sv
// Round-robin front end sharing one 1-in/N-out multiplier datapath.
// Per-burst owner tags are queued so returned bursts route home in order.
module sparse_mult_arbiter #(
  parameter int WIDTH         = 96,
  parameter int NUM_REQ       = 4,
  parameter int OUTPUT_LENGTH = 11,
  parameter int TAG_DEPTH     = 4
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic [NUM_REQ*WIDTH-1:0]         i_req_data,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [WIDTH-1:0]                 o_mult_data,
  output logic                             o_mult_valid,
  input  logic                             i_mult_ready,
  input  logic [WIDTH-1:0]                 i_mult_data,
  input  logic                             i_mult_valid,
  output logic                             o_mult_ready,
  output logic [WIDTH-1:0]                 o_rsp_data,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic                             o_rsp_last,
  input  logic [NUM_REQ-1:0]               i_rsp_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   o_outstanding,
  output logic                             o_err
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int BW = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RW-1:0]     r_rr;
  logic [RW-1:0]     w_win;
  logic [RW-1:0]     w_idx;
  logic              w_any;
  logic              w_grant;
  logic [WIDTH-1:0]  r_issue_data;
  logic [RW-1:0]     r_tags [TAG_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_beat;
  logic              r_err;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_beat_hs;
  logic              w_last;
  logic [RW-1:0]     w_head;

  // first valid requester strictly after the last winner, wrapping
  always_comb begin
    w_any = 1'b0;
    w_win = r_rr;
    w_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = RW'((int'(r_rr) + i) % NUM_REQ);
      if (!w_any && i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(TAG_DEPTH));
  assign w_grant = (r_state == ST_IDLE) && w_any && !w_full && i_reset_n;
  assign w_push  = w_grant;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (i_mult_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_head    = r_tags[r_rd_ptr];
  assign w_last    = (r_beat == BW'(OUTPUT_LENGTH - 1));
  assign w_beat_hs = i_mult_valid && o_mult_ready;
  assign w_pop     = w_beat_hs && w_last;

  assign o_req_ready   = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign o_mult_valid  = (r_state == ST_ISSUE);
  assign o_mult_data   = r_issue_data;
  assign o_mult_ready  = !w_empty && i_rsp_ready[w_head];
  assign o_rsp_data    = w_empty ? '0 : i_mult_data;
  assign o_rsp_valid   = (!w_empty && i_mult_valid) ?
                         (NUM_REQ'(1) << w_head) : '0;
  assign o_rsp_last    = !w_empty && i_mult_valid && w_last;
  assign o_outstanding = r_count;
  assign o_err         = r_err;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_rr         <= RW'(NUM_REQ - 1);
      r_issue_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_rr         <= w_win;
        r_issue_data <= i_req_data[w_win*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) r_tags[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_win;
        r_wr_ptr <= (r_wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_beat_hs) r_beat <= w_last ? '0 : r_beat + 1'b1;
      // stray datapath output with no owner is flagged, never consumed
      if (w_empty && i_mult_valid) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sparse_mult_arbiter.sv
// Directed bench for sparse_mult_arbiter.
// Grants, burst routing, stalls, FIFO limits, error and reset.
module tb_sparse_mult_arbiter;

  localparam int W = 96;
  localparam int N = 4;
  localparam int L = 11;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   i_req_data;
  logic [N-1:0]     i_req_valid;
  logic [N-1:0]     o_req_ready;
  logic [W-1:0]     o_mult_data;
  logic             o_mult_valid;
  logic             i_mult_ready;
  logic [W-1:0]     i_mult_data;
  logic             i_mult_valid;
  logic             o_mult_ready;
  logic [W-1:0]     o_rsp_data;
  logic [N-1:0]     o_rsp_valid;
  logic             o_rsp_last;
  logic [N-1:0]     i_rsp_ready;
  logic [2:0]       o_outstanding;
  logic             o_err;

  int n_tests = 0;
  int n_fail  = 0;

  sparse_mult_arbiter #(
    .WIDTH(W), .NUM_REQ(N), .OUTPUT_LENGTH(L), .TAG_DEPTH(D)
  ) u_dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_req_data   (i_req_data),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .o_mult_data  (o_mult_data),
    .o_mult_valid (o_mult_valid),
    .i_mult_ready (i_mult_ready),
    .i_mult_data  (i_mult_data),
    .i_mult_valid (i_mult_valid),
    .o_mult_ready (o_mult_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_last   (o_rsp_last),
    .i_rsp_ready  (i_rsp_ready),
    .o_outstanding(o_outstanding),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] d);
    i_req_data[k*W +: W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic beats(input int req, input int from, input int to);
    for (int b = from; b <= to; b++) begin
      i_mult_valid = 1'b1;
      i_mult_data  = W'(req * 256 + b);
      #1;
      check("rsp_valid", o_rsp_valid, N'(1) << req);
      check("rsp_last", o_rsp_last, b == L - 1);
      check("rsp_data", o_rsp_data, W'(req * 256 + b));
      tick();
    end
    i_mult_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_req_data   = '0;
    i_req_valid  = '0;
    i_mult_ready = 1'b0;
    i_mult_data  = '0;
    i_mult_valid = 1'b0;
    i_rsp_ready  = '1;
    do_reset();

    #1;
    check("rst_req_ready", o_req_ready, 0);
    check("rst_mult_valid", o_mult_valid, 0);
    check("rst_mult_data", o_mult_data, 0);
    check("rst_outstanding", o_outstanding, 0);
    check("rst_err", o_err, 0);

    // single requester 2
    set_req(2, W'('hA5));
    i_req_valid = 4'b0100;
    #1;
    check("t1_grant", o_req_ready, 4'b0100);
    tick();
    i_req_valid = '0;
    #1;
    check("t1_mvalid", o_mult_valid, 1);
    check("t1_mdata", o_mult_data, 'hA5);
    check("t1_out1", o_outstanding, 1);
    i_mult_ready = 1'b1;
    tick();
    i_mult_ready = 1'b0;
    check("t1_idle", o_mult_valid, 0);
    beats(2, 0, L - 1);
    check("t1_out0", o_outstanding, 0);

    // all four requesters, fill the FIFO
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, W'('h100 + k));
    i_req_valid  = 4'hF;
    i_mult_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      #1;
      check("t2_grant", o_req_ready, N'(1) << k);
      tick();
      check("t2_issue_rdy", o_req_ready, 0);
      check("t2_mdata", o_mult_data, W'('h100 + k));
      tick();
    end
    #1;
    check("t4_full_rdy", o_req_ready, 0);
    check("t4_out4", o_outstanding, 4);
    tick();
    check("t4_full_rdy2", o_req_ready, 0);
    i_req_valid = '0;
    beats(0, 0, L - 1);
    check("t4_out3", o_outstanding, 3);
    beats(1, 0, L - 2);
    i_req_valid  = 4'b0010;
    i_mult_valid = 1'b1;
    i_mult_data  = W'(256 + L - 1);
    #1;
    check("t4_pp_grant", o_req_ready, 4'b0010);
    check("t4_pp_last", o_rsp_last, 1);
    tick();
    i_req_valid  = '0;
    i_mult_valid = 1'b0;
    #1;
    check("t4_pp_count", o_outstanding, 3);
    check("t4_pp_issue", o_mult_data, W'('h101));
    tick();
    beats(2, 0, L - 1);
    beats(3, 0, L - 1);
    beats(1, 0, L - 1);
    check("t2_out0", o_outstanding, 0);

    // issue stall
    i_mult_ready = 1'b0;
    set_req(3, W'('hBEEF));
    i_req_valid = 4'b1000;
    #1;
    check("t3_grant", o_req_ready, 4'b1000);
    tick();
    i_req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_mdata", o_mult_data, 'hBEEF);
      check("t3_mvalid", o_mult_valid, 1);
      check("t3_rdy", o_req_ready, 0);
      check("t3_out", o_outstanding, 1);
      tick();
    end
    i_req_valid  = '0;
    i_mult_ready = 1'b1;
    tick();
    i_mult_ready = 1'b0;
    check("t3_done", o_mult_valid, 0);
    check("t3_out_after", o_outstanding, 1);

    // response backpressure at beat 3
    beats(3, 0, 2);
    i_mult_valid = 1'b1;
    i_mult_data  = W'(3 * 256 + 3);
    i_rsp_ready  = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t5_mready", o_mult_ready, 0);
      check("t5_valid", o_rsp_valid, 4'b1000);
      check("t5_last", o_rsp_last, 0);
      tick();
    end
    i_rsp_ready = '1;
    beats(3, 3, L - 1);
    check("t5_out0", o_outstanding, 0);

    // stray output, then reset mid-burst
    i_mult_valid = 1'b1;
    i_mult_data  = W'('h77);
    #1;
    check("t6_mready", o_mult_ready, 0);
    check("t6_rvalid", o_rsp_valid, 0);
    tick();
    i_mult_valid = 1'b0;
    #1;
    check("t6_err", o_err, 1);
    tick();
    tick();
    check("t6_err_sticky", o_err, 1);
    check("t6_out", o_outstanding, 0);
    i_req_valid  = 4'b0001;
    i_mult_ready = 1'b1;
    tick();
    i_req_valid = '0;
    tick();
    beats(0, 0, 1);
    i_mult_valid = 1'b1;
    i_req_valid  = 4'hF;
    #1;
    check("t6_mid", o_rsp_valid, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6r_req_ready", o_req_ready, 0);
    check("t6r_mvalid", o_mult_valid, 0);
    check("t6r_mdata", o_mult_data, 0);
    check("t6r_mready", o_mult_ready, 0);
    check("t6r_rvalid", o_rsp_valid, 0);
    check("t6r_rlast", o_rsp_last, 0);
    check("t6r_rdata", o_rsp_data, 0);
    check("t6r_out", o_outstanding, 0);
    check("t6r_err", o_err, 0);
    i_req_valid  = '0;
    i_mult_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_err_clr", o_err, 0);
    set_req(2, W'('h5A));
    i_req_valid = 4'b0100;
    #1;
    check("t6_regrant", o_req_ready, 4'b0100);
    tick();
    i_req_valid = '0;
    check("t6_mdata", o_mult_data, 'h5A);
    tick();
    beats(2, 0, L - 1);
    check("t6_out0", o_outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
